pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Hazard and sequencing controller for the 3-stage RV32I pipeline: stage 1 is IF/ID, stage 2 is EX, stage 3 is MEM/WB.
- Keeps shadow copies of the EX and WB instructions.
- Produces per-operand forwarding selects for stage 1, load-use stalls, branch/jump flushes and data-memory wait freezes.
- Sits beside the datapath and drives its pipeline-register enables and bubble insertion.

Parameters:
NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0).
XLEN, 32, instruction width.

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
inst_id  in  32  instruction currently in stage 1
inst_id_valid  in  1  stage 1 holds a real instruction
redirect  in  1  branch taken / JAL / JALR resolved in EX this cycle
dmem_ready  in  1  data memory completes the stage-3 access this cycle
stall_if  out  1  hold PC and the IF/ID register
bubble_ex  out  1  NOP is being loaded into EX
flush  out  1  kill the IF/ID contents (redirect accepted)
rs1_fwd_sel  out  2  00 regfile, 01 EX result, 10 WB result
rs2_fwd_sel  out  2  same encoding
inst_ex  out  32  instruction registered in stage 2
inst_wb  out  32  instruction registered in stage 3
state  out  2  00 RUN, 01 LOAD_STALL, 10 MEM_WAIT, 11 FLUSH

Behaviour:
Decode rules, shared with the forwarding logic:
- rd is written unless the opcode is STORE (0100011) or BRANCH (1100011).
- rs1 is read unless the opcode is LUI, AUIPC or JAL.
- rs2 is read only for OP (0110011), STORE and BRANCH.
- rd==x0 never matches.
- inst_id_valid=0 means stage 1 reads nothing.

Forward selects (combinational from inst_id, inst_ex, inst_wb):
- Select 01 when inst_ex writes rd and rd matches the operand; select 10 when inst_wb matches.
- EX wins over WB.
- Force 00 whenever stall_if=1.

Load-use hazard: inst_ex is LOAD (0000011) and its rd matches a read operand of inst_id.

Per-cycle priority, highest first:
1. MEM_WAIT condition: inst_wb is LOAD or STORE and dmem_ready=0.
   - stall_if=1; inst_ex and inst_wb hold; bubble_ex=0, flush=0; state=MEM_WAIT.
   - Leave on the first cycle dmem_ready=1, then re-evaluate the lower priorities that same cycle.
   - A redirect arriving during MEM_WAIT is held off. The datapath keeps redirect asserted because EX is frozen.
2. redirect=1:
   - flush=1, bubble_ex=1, stall_if=0.
   - Next edge: inst_ex<=NOP_INST, inst_wb<=old inst_ex.
   - state=FLUSH for exactly 1 cycle, then RUN.
3. Load-use hazard:
   - stall_if=1, bubble_ex=1.
   - Next edge: inst_ex<=NOP_INST, inst_wb<=old inst_ex.
   - state=LOAD_STALL for 1 cycle. In RUN the next cycle, the consumer receives sel=10.
4. Otherwise RUN:
   - inst_ex<=(inst_id_valid ? inst_id : NOP_INST), inst_wb<=inst_ex.

Reset (async assert, sync release):
- inst_ex=inst_wb=NOP_INST, state=RUN.
- stall_if, bubble_ex and flush are 0; both selects are 00.
- Reset mid-stall or mid-MEM_WAIT aborts immediately, with no residual stall.

Back-to-back cases:
- Load-use immediately after a flush: evaluated normally (NOP in EX, so no hazard).
- Two consecutive loads feeding each other: one stall per dependent pair.

Optional Feature:
HAZARD_PERF_CNT_EN:
- When defined, adds outputs stall_cnt[31:0] and flush_cnt[31:0], both reset to 0.
- stall_cnt increments each cycle stall_if=1; flush_cnt increments each cycle flush=1.
- Both wrap at 2^32.
- When undefined, neither the ports nor the counters exist and the rest of the behaviour is identical.

Decomposition:
Shared package pipe_pkg holds:
- the opcode localparams (RTYPE, IMMTYPE, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR);
- NOP_INST;
- the fwd_sel encoding constants;
- the state enum.

One sub-module, hazard_decode: purely combinational. Per instruction it returns uses_rd, uses_rs1, uses_rs2, is_load and is_mem. The controller instantiates it three times (ID, EX, WB).

Test Plan:
1. add x5,x1,x2 then sub x6,x5,x3 back-to-back -> cycle 2: rs1_fwd_sel=01, no stall. One cycle later with an unrelated instruction between -> rs1_fwd_sel=10.
2. lw x7,0(x1) then add x8,x7,x7 -> 1 cycle: stall_if=1, bubble_ex=1, state=LOAD_STALL, inst_ex=32'h13. Next cycle: rs1_fwd_sel=rs2_fwd_sel=10.
3. beq taken in EX (redirect=1) with a dependent lw-use pair in ID -> flush=1, bubble_ex=1, stall_if=0, state=FLUSH. Load-use is suppressed.
4. sw in WB with dmem_ready low for 3 cycles -> stall_if=1 for 3 cycles, inst_ex/inst_wb unchanged, state=MEM_WAIT. Ready cycle -> RUN.
5. addi x0,x1,1 then add x2,x0,x0 -> both selects 00. lui x3 then lui x4 -> rs1_fwd_sel=00.
6. Assert rst_n=0 mid-LOAD_STALL -> outputs return to reset values immediately. With HAZARD_PERF_CNT_EN, stall_cnt=0 after reset and counts 3 after scenario 4.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Purpose: shared opcodes, bubble word, forward-select codes and controller state for the RV32I hazard unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_pkg;

    localparam int XLEN = 32;

    // addi x0,x0,0 -- what EX receives when a bubble is inserted
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    localparam logic [6:0] RTYPE   = 7'b0110011;
    localparam logic [6:0] IMMTYPE = 7'b0010011;
    localparam logic [6:0] LOAD    = 7'b0000011;
    localparam logic [6:0] STORE   = 7'b0100011;
    localparam logic [6:0] BRANCH  = 7'b1100011;
    localparam logic [6:0] LUI     = 7'b0110111;
    localparam logic [6:0] AUIPC   = 7'b0010111;
    localparam logic [6:0] JAL     = 7'b1101111;
    localparam logic [6:0] JALR    = 7'b1100111;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_EX = 2'b01;
    localparam logic [1:0] FWD_WB = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN        = 2'b00,
        ST_LOAD_STALL = 2'b01,
        ST_MEM_WAIT   = 2'b10,
        ST_FLUSH      = 2'b11
    } state_t;

    // Register fields plus the usage flags the hazard logic needs per instruction
    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses_rd;
        logic       uses_rs1;
        logic       uses_rs2;
        logic       is_load;
        logic       is_mem;
    } dec_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Purpose: bundle between the datapath (master) and the hazard controller (slave).
// Latency: n/a (wires only).
// Backpressure: stall_if/bubble_ex/flush travel slave->master; datapath obeys them the same cycle.
// Signals: inst_id, inst_id_valid, redirect, dmem_ready (datapath -> controller);
//          stall_if, bubble_ex, flush, rs1/rs2_fwd_sel, inst_ex, inst_wb, state (controller -> datapath);
//          stall_cnt, flush_cnt only when HAZARD_PERF_CNT_EN is defined.
interface pipeline_hazard_ctrl_if;
    import pipe_pkg::*;

    logic [XLEN-1:0] inst_id;
    logic            inst_id_valid;
    logic            redirect;
    logic            dmem_ready;
    logic            stall_if;
    logic            bubble_ex;
    logic            flush;
    logic [1:0]      rs1_fwd_sel;
    logic [1:0]      rs2_fwd_sel;
    logic [XLEN-1:0] inst_ex;
    logic [XLEN-1:0] inst_wb;
    state_t          state;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]     stall_cnt;
    logic [31:0]     flush_cnt;
`endif

    modport master (
        output inst_id, inst_id_valid, redirect, dmem_ready,
        input  stall_if, bubble_ex, flush, rs1_fwd_sel, rs2_fwd_sel, inst_ex, inst_wb, state
`ifdef HAZARD_PERF_CNT_EN
        , input stall_cnt, flush_cnt
`endif
    );

    modport slave (
        input  inst_id, inst_id_valid, redirect, dmem_ready,
        output stall_if, bubble_ex, flush, rs1_fwd_sel, rs2_fwd_sel, inst_ex, inst_wb, state
`ifdef HAZARD_PERF_CNT_EN
        , output stall_cnt, flush_cnt
`endif
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_decode.sv
// Purpose: classify one RV32I instruction for hazard detection (register use, load, memory access).
// Latency: combinational.
// Backpressure: none.
// Ports: inst (instruction word) -> dec (fields and usage flags).
module hazard_decode
    import pipe_pkg::*;
(
    input  logic [XLEN-1:0] inst,
    output dec_t            dec
);

    logic [6:0] opc;
    logic       unused_inst;

    assign opc         = inst[6:0];
    assign unused_inst = ^{inst[31:25], inst[14:12]};

    always_comb begin
        dec          = '0;
        dec.rd       = inst[11:7];
        dec.rs1      = inst[19:15];
        dec.rs2      = inst[24:20];
        // x0 is folded in here so that no consumer ever matches a write to x0
        dec.uses_rd  = (opc != STORE) && (opc != BRANCH) && (inst[11:7] != 5'd0);
        dec.uses_rs1 = (opc != LUI) && (opc != AUIPC) && (opc != JAL);
        dec.uses_rs2 = (opc == RTYPE) || (opc == STORE) || (opc == BRANCH);
        dec.is_load  = (opc == LOAD);
        dec.is_mem   = (opc == LOAD) || (opc == STORE);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Purpose: hazard/sequencing control for a 3-stage RV32I pipeline: forwarding, load-use stall, redirect flush, dmem wait.
// Latency: control outputs combinational from current inputs; shadow EX/WB instructions update on each clk edge.
// Backpressure: dmem wait freezes EX/WB and stalls IF; load-use stalls IF and bubbles EX; redirect flushes IF/ID.
// Ports: clk, rst_n (async active-low), hz (pipeline_hazard_ctrl_if.slave).
// Build option: HAZARD_PERF_CNT_EN adds stall_cnt/flush_cnt cycle counters on the interface.
module pipeline_hazard_ctrl
    import pipe_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    pipeline_hazard_ctrl_if.slave hz
);

    dec_t            dec_id, dec_ex, dec_wb;
    logic [XLEN-1:0] inst_ex_q, inst_wb_q, inst_ex_d, inst_wb_d;
    state_t          prev_state_q, state_d;
    logic            id_rs1, id_rs2;
    logic            mem_wait, redirect_ok, load_use;
    logic            stall_d, bubble_d, flush_d;
    logic [1:0]      rs1_sel, rs2_sel;
    logic            unused_dec;

    hazard_decode u_dec_id (.inst(hz.inst_id), .dec(dec_id));
    hazard_decode u_dec_ex (.inst(inst_ex_q),  .dec(dec_ex));
    hazard_decode u_dec_wb (.inst(inst_wb_q),  .dec(dec_wb));

    assign unused_dec = ^{dec_id.rd, dec_id.uses_rd, dec_id.is_load, dec_id.is_mem,
                          dec_ex.rs1, dec_ex.rs2, dec_ex.uses_rs1, dec_ex.uses_rs2, dec_ex.is_mem,
                          dec_wb.rs1, dec_wb.rs2, dec_wb.uses_rs1, dec_wb.uses_rs2, dec_wb.is_load};

    // An invalid stage-1 slot reads nothing, so it can neither forward nor stall
    assign id_rs1 = hz.inst_id_valid && dec_id.uses_rs1;
    assign id_rs2 = hz.inst_id_valid && dec_id.uses_rs2;

    assign mem_wait = dec_wb.is_mem && !hz.dmem_ready;

    // After a flush EX holds a bubble, so a redirect still high that cycle is stale;
    // ignoring it keeps FLUSH to exactly one cycle.
    assign redirect_ok = hz.redirect && (prev_state_q != ST_FLUSH);

    assign load_use = dec_ex.is_load && dec_ex.uses_rd &&
                      ((id_rs1 && (dec_id.rs1 == dec_ex.rd)) ||
                       (id_rs2 && (dec_id.rs2 == dec_ex.rd)));

    always_comb begin
        state_d   = ST_RUN;
        stall_d   = 1'b0;
        bubble_d  = 1'b0;
        flush_d   = 1'b0;
        inst_ex_d = hz.inst_id_valid ? hz.inst_id : NOP_INST;
        inst_wb_d = inst_ex_q;
        if (mem_wait) begin
            // Whole back end frozen; a pending redirect waits because EX is frozen too
            state_d   = ST_MEM_WAIT;
            stall_d   = 1'b1;
            inst_ex_d = inst_ex_q;
            inst_wb_d = inst_wb_q;
        end else if (redirect_ok) begin
            state_d   = ST_FLUSH;
            flush_d   = 1'b1;
            bubble_d  = 1'b1;
            inst_ex_d = NOP_INST;
        end else if (load_use) begin
            state_d   = ST_LOAD_STALL;
            stall_d   = 1'b1;
            bubble_d  = 1'b1;
            inst_ex_d = NOP_INST;
        end
    end

    // EX result beats WB result; a stalled consumer is re-evaluated next cycle anyway
    always_comb begin
        rs1_sel = FWD_RF;
        rs2_sel = FWD_RF;
        if (!stall_d) begin
            if (id_rs1 && dec_ex.uses_rd && (dec_ex.rd == dec_id.rs1))      rs1_sel = FWD_EX;
            else if (id_rs1 && dec_wb.uses_rd && (dec_wb.rd == dec_id.rs1)) rs1_sel = FWD_WB;
            if (id_rs2 && dec_ex.uses_rd && (dec_ex.rd == dec_id.rs2))      rs2_sel = FWD_EX;
            else if (id_rs2 && dec_wb.uses_rd && (dec_wb.rd == dec_id.rs2)) rs2_sel = FWD_WB;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_ex_q    <= NOP_INST;
            inst_wb_q    <= NOP_INST;
            prev_state_q <= ST_RUN;
        end else begin
            inst_ex_q    <= inst_ex_d;
            inst_wb_q    <= inst_wb_d;
            prev_state_q <= state_d;
        end
    end

    assign hz.stall_if    = stall_d;
    assign hz.bubble_ex   = bubble_d;
    assign hz.flush       = flush_d;
    assign hz.rs1_fwd_sel = rs1_sel;
    assign hz.rs2_fwd_sel = rs2_sel;
    assign hz.inst_ex     = inst_ex_q;
    assign hz.inst_wb     = inst_wb_q;
    assign hz.state       = state_d;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    // Free-running, wrap naturally at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (stall_d) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush_d) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Purpose: scoreboard bench for pipeline_hazard_ctrl: directed pipeline scenarios plus randomized instruction streams.
// Latency: expectations are per cycle; outputs sampled on the falling edge.
// Backpressure: the stimulus side holds stage 1 whenever stall_if is expected, as a real datapath would.
module tb_pipeline_hazard_ctrl;
    import pipe_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if ifc();
    pipeline_hazard_ctrl dut (.clk(clk), .rst_n(rst_n), .hz(ifc));

    typedef struct {
        logic        stall_if;
        logic        bubble_ex;
        logic        flush;
        logic [1:0]  sel1;
        logic [1:0]  sel2;
        logic [31:0] ex;
        logic [31:0] wb;
        logic [1:0]  st;
        logic [31:0] scnt;
        logic [31:0] fcnt;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Reference pipeline contents and counters
    logic [31:0] m_ex   = NOP_INST;
    logic [31:0] m_wb   = NOP_INST;
    logic [31:0] m_scnt = 0;
    logic [31:0] m_fcnt = 0;
    bit          m_taken = 0;

    function automatic bit writes_rd(logic [31:0] i);
        return (i[6:0] != STORE) && (i[6:0] != BRANCH) && (i[11:7] != 5'd0);
    endfunction
    function automatic bit reads_rs1(logic [31:0] i);
        return (i[6:0] != LUI) && (i[6:0] != AUIPC) && (i[6:0] != JAL);
    endfunction
    function automatic bit reads_rs2(logic [31:0] i);
        return (i[6:0] == RTYPE) || (i[6:0] == STORE) || (i[6:0] == BRANCH);
    endfunction
    function automatic bit is_ctrl(logic [31:0] i);
        return (i[6:0] == BRANCH) || (i[6:0] == JAL) || (i[6:0] == JALR);
    endfunction

    // Where the newest value of register r comes from, given what EX and WB hold
    function automatic logic [1:0] source_of(bit reads, logic [4:0] r);
        if (!reads) return 2'd0;
        if (writes_rd(m_ex) && m_ex[11:7] == r) return 2'd1;
        if (writes_rd(m_wb) && m_wb[11:7] == r) return 2'd2;
        return 2'd0;
    endfunction

    function automatic exp_t predict(logic [31:0] id, bit v, bit redir, bit rdy);
        exp_t e;
        bit   mw, lu;
        e.ex = m_ex; e.wb = m_wb; e.scnt = m_scnt; e.fcnt = m_fcnt;
        e.stall_if = 0; e.bubble_ex = 0; e.flush = 0; e.st = 2'd0;
        mw = (m_wb[6:0] == LOAD || m_wb[6:0] == STORE) && !rdy;
        lu = v && (m_ex[6:0] == LOAD) && writes_rd(m_ex) &&
             ((reads_rs1(id) && id[19:15] == m_ex[11:7]) || (reads_rs2(id) && id[24:20] == m_ex[11:7]));
        if (mw)         begin e.stall_if = 1; e.st = 2'd2; end
        else if (redir) begin e.flush = 1; e.bubble_ex = 1; e.st = 2'd3; end
        else if (lu)    begin e.stall_if = 1; e.bubble_ex = 1; e.st = 2'd1; end
        e.sel1 = e.stall_if ? 2'd0 : source_of(v && reads_rs1(id), id[19:15]);
        e.sel2 = e.stall_if ? 2'd0 : source_of(v && reads_rs2(id), id[24:20]);
        return e;
    endfunction

    task automatic advance(input exp_t e, input logic [31:0] id, input bit v);
        if (e.st == 2'd2) begin
            // frozen
        end else if (e.st != 2'd0) begin
            m_wb = m_ex; m_ex = NOP_INST; m_taken = 0;
        end else begin
            m_wb = m_ex; m_ex = v ? id : NOP_INST; m_taken = ($urandom_range(0, 1) == 1);
        end
        m_scnt = m_scnt + {31'd0, e.stall_if};
        m_fcnt = m_fcnt + {31'd0, e.flush};
    endtask

    task automatic step(input logic [31:0] id, input bit v, input bit redir, input bit rdy, output bit stalled);
        exp_t e;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ifc.inst_id = id; ifc.inst_id_valid = v; ifc.redirect = redir; ifc.dmem_ready = rdy;
        e = predict(id, v, redir, rdy);
        sb.push_back(e);
        stalled = e.stall_if;
        advance(e, id, v);
    endtask

    task automatic do_reset(input logic [31:0] id, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk); #1;
            rst_n = 1'b0;
            ifc.inst_id = id; ifc.inst_id_valid = 1'b1; ifc.redirect = 1'b0;
            ifc.dmem_ready = 1'($urandom_range(0, 1));
            m_ex = NOP_INST; m_wb = NOP_INST; m_scnt = 0; m_fcnt = 0; m_taken = 0;
            sb.push_back(predict(id, 1'b1, 1'b0, ifc.dmem_ready));
        end
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops [9];
        logic [31:0] r;
        ops = '{RTYPE, IMMTYPE, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR};
        r = $urandom;
        r[6:0]   = ops[$urandom_range(0, 8)];
        r[11:7]  = 5'($urandom_range(0, 3));
        r[19:15] = 5'($urandom_range(0, 3));
        r[24:20] = 5'($urandom_range(0, 3));
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("stall_if",    {31'd0, ifc.stall_if},    {31'd0, e.stall_if});
            chk("bubble_ex",   {31'd0, ifc.bubble_ex},   {31'd0, e.bubble_ex});
            chk("flush",       {31'd0, ifc.flush},       {31'd0, e.flush});
            chk("rs1_fwd_sel", {30'd0, ifc.rs1_fwd_sel}, {30'd0, e.sel1});
            chk("rs2_fwd_sel", {30'd0, ifc.rs2_fwd_sel}, {30'd0, e.sel2});
            chk("inst_ex",     ifc.inst_ex,              e.ex);
            chk("inst_wb",     ifc.inst_wb,              e.wb);
            chk("state",       {30'd0, ifc.state},       {30'd0, e.st});
`ifdef HAZARD_PERF_CNT_EN
            chk("stall_cnt",   ifc.stall_cnt,            e.scnt);
            chk("flush_cnt",   ifc.flush_cnt,            e.fcnt);
`endif
        end
    end

    initial begin
        logic [31:0] add_a, sub_b, unrel, lw7, add_dep, beq_i, sw_i, addi0, add_x0, lui3, lui4, lw8, add9, cur_id;
        bit          stl, cur_v, redir;
        add_a   = {7'd0, 5'd2, 5'd1, 3'b000, 5'd5, RTYPE};
        sub_b   = {7'h20, 5'd3, 5'd5, 3'b000, 5'd6, RTYPE};
        unrel   = {12'd1, 5'd0, 3'b000, 5'd9, IMMTYPE};
        lw7     = {12'd0, 5'd1, 3'b010, 5'd7, LOAD};
        add_dep = {7'd0, 5'd7, 5'd7, 3'b000, 5'd8, RTYPE};
        beq_i   = {7'd0, 5'd2, 5'd1, 3'b000, 5'd0, BRANCH};
        sw_i    = {7'd0, 5'd2, 5'd1, 3'b010, 5'd0, STORE};
        addi0   = {12'd1, 5'd1, 3'b000, 5'd0, IMMTYPE};
        add_x0  = {7'd0, 5'd0, 5'd0, 3'b000, 5'd2, RTYPE};
        lui3    = {20'h12345, 5'd3, LUI};
        lui4    = {20'h23456, 5'd4, LUI};
        lw8     = {12'd0, 5'd7, 3'b010, 5'd8, LOAD};
        add9    = {7'd0, 5'd8, 5'd8, 3'b000, 5'd9, RTYPE};
        ifc.inst_id = NOP_INST; ifc.inst_id_valid = 1'b0; ifc.redirect = 1'b0; ifc.dmem_ready = 1'b1;

        #2 rst_n = 1'b0;
        do_reset(NOP_INST, 3);

        // store waiting three cycles on data memory, counters from zero
        step(sw_i, 1, 0, 1, stl);
        step(NOP_INST, 0, 0, 1, stl);
        repeat (3) step(NOP_INST, 0, 0, 0, stl);
        step(NOP_INST, 0, 0, 1, stl);
        step(NOP_INST, 0, 0, 1, stl);

        // EX then WB forwarding
        step(add_a, 1, 0, 1, stl);
        step(sub_b, 1, 0, 1, stl);
        step(add_a, 1, 0, 1, stl);
        step(unrel, 1, 0, 1, stl);
        step(sub_b, 1, 0, 1, stl);

        // load-use: stall once, then WB forwarding on both operands
        step(lw7, 1, 0, 1, stl);
        step(add_dep, 1, 0, 1, stl);
        step(add_dep, 1, 0, 1, stl);
        step(NOP_INST, 0, 0, 1, stl);

        // redirect outranks load-use
        step(lw7, 1, 0, 1, stl);
        step(add_dep, 1, 1, 1, stl);
        step(unrel, 1, 0, 1, stl);

        // redirect held off behind a memory wait
        step(beq_i, 1, 0, 1, stl);
        step(lw7, 1, 0, 1, stl);
        step(NOP_INST, 0, 1, 1, stl);
        step(NOP_INST, 0, 1, 0, stl);
        step(NOP_INST, 0, 1, 1, stl);
        step(NOP_INST, 0, 0, 1, stl);

        // x0 never forwards; LUI reads nothing
        step(addi0, 1, 0, 1, stl);
        step(add_x0, 1, 0, 1, stl);
        step(lui3, 1, 0, 1, stl);
        step(lui4, 1, 0, 1, stl);

        // chained loads: one stall per dependent pair
        step(lw7, 1, 0, 1, stl);
        step(lw8, 1, 0, 1, stl);
        step(lw8, 1, 0, 1, stl);
        step(add9, 1, 0, 1, stl);
        step(add9, 1, 0, 1, stl);

        // reset while a load-use stall is in progress
        step(lw7, 1, 0, 1, stl);
        do_reset(add_dep, 2);
        step(add_dep, 1, 0, 1, stl);

        // randomized streams
        stl = 0; cur_id = NOP_INST; cur_v = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!stl) begin
                cur_id = rand_inst();
                cur_v  = ($urandom_range(0, 7) != 0);
            end
            redir = is_ctrl(m_ex) && m_taken;
            step(cur_id, cur_v, redir, ($urandom_range(0, 2) != 0), stl);
            if ($urandom_range(0, 299) == 0) begin
                do_reset(cur_id, 1);
                stl = 0;
            end
        end

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
